fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 40 ++++
 rtl/pc_unit.sv | 61 ++++++
 rtl/fetch_stage.sv | 71 +++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared processor constants and types for the instruction fetch stage.
// Holds the bubble encoding, default reset PC and next-PC helpers.
package fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_PC_PLUS4  = 32'h0000_0000;
    localparam logic        BUBBLE_VALID     = 1'b0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    typedef enum logic [1:0] {
        PC_SEL_BRANCH = 2'd0,
        PC_SEL_JUMP   = 2'd1,
        PC_SEL_HOLD   = 2'd2,
        PC_SEL_ADV    = 2'd3
    } pc_sel_e;

    function automatic ifid_t ifid_bubble(input logic [31:0] nop_word);
        ifid_t b;
        b.instr    = nop_word;
        b.pc_plus4 = BUBBLE_PC_PLUS4;
        b.valid    = BUBBLE_VALID;
        return b;
    endfunction

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Wraps naturally at 2^32 because the sum is truncated to 32 bits.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter register with its redirect/stall priority mux.
// Redirects override a stall; reset overrides everything.
module pc_unit
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    pc_sel_e     pc_sel_s;
    logic [31:0] pc_next_s;
    logic [31:0] pc_r;

    // Select the next-PC source by priority.
    always_comb begin
        pc_sel_s = PC_SEL_ADV;
        if (branch_taken) begin
            pc_sel_s = PC_SEL_BRANCH;
        end else if (jump) begin
            pc_sel_s = PC_SEL_JUMP;
        end else if (stall) begin
            pc_sel_s = PC_SEL_HOLD;
        end else begin
            pc_sel_s = PC_SEL_ADV;
        end
    end

    // Form the next PC from the selected source.
    always_comb begin
        pc_next_s = pc_inc(pc_r);
        case (pc_sel_s)
            PC_SEL_BRANCH: pc_next_s = word_align(branch_target);
            PC_SEL_JUMP:   pc_next_s = word_align(jump_target);
            PC_SEL_HOLD:   pc_next_s = pc_r;
            PC_SEL_ADV:    pc_next_s = pc_inc(pc_r);
            default:       pc_next_s = RESET_PC;
        endcase
    end

    // PC register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= word_align(RESET_PC);
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc       = pc_r;
    assign pc_plus4 = pc_inc(pc_r);

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory address from the PC
// and captures the fetched word into the IF/ID pipeline register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemData,
    output logic [31:0] IfIdInstruction,
    output logic [31:0] IfIdPCPlus4,
    output logic        IfIdValid
);

    logic [31:0] pc_s;
    logic [31:0] pc_plus4_s;
    ifid_t       ifid_next_s;
    ifid_t       ifid_r;

    pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk           (Clk),
        .reset         (Reset),
        .stall         (Stall),
        .branch_taken  (BranchTaken),
        .branch_target (BranchTarget),
        .jump          (Jump),
        .jump_target   (JumpTarget),
        .pc            (pc_s),
        .pc_plus4      (pc_plus4_s)
    );

    // Any redirect or flush squashes the word fetched this cycle.
    always_comb begin
        ifid_next_s = ifid_r;
        if (BranchTaken || Jump || Flush) begin
            ifid_next_s = ifid_bubble(NOP_WORD);
        end else if (Stall) begin
            ifid_next_s = ifid_r;
        end else begin
            ifid_next_s.instr    = IMemData;
            ifid_next_s.pc_plus4 = pc_plus4_s;
            ifid_next_s.valid    = 1'b1;
        end
    end

    // IF/ID pipeline register with synchronous reset to a bubble.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ifid_r <= ifid_bubble(NOP_WORD);
        end else begin
            ifid_r <= ifid_next_s;
        end
    end

    assign IMemAddr        = pc_s;
    assign IfIdInstruction = ifid_r.instr;
    assign IfIdPCPlus4     = ifid_r.pc_plus4;
    assign IfIdValid       = ifid_r.valid;

endmodule
